// File: rtl/result_collector.sv
// Captures each core's result on the rising edge of out_en==1 and streams the results in strict
// round-robin core order through a first-word-fall-through FIFO with a registered output stage.

module result_collector #(
   parameter int N_CORES    = 24,
   parameter int DATA_W     = 28,
   parameter int EN_W       = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_CORES*DATA_W-1:0]   core_out,
   input  logic [N_CORES*EN_W-1:0]     core_en,
   output logic signed [DATA_W-1:0]    m_data,
   output logic [4:0]                  m_core,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic                        overrun,
   output logic [15:0]                 res_cnt
);

   localparam int CW = 5;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0]   LAST_CORE = CW'(N_CORES - 1);
   localparam logic [EN_W-1:0] EN_VALID  = EN_W'(1);
   localparam logic [AW:0]     FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
   localparam logic [AW:0]     ONE_CNT   = (AW + 1)'(1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_PUSH = 1'b1
   } state_t;

   state_t               state_q;
   logic [CW-1:0]        rr_ptr_q;
   logic [CW-1:0]        rr_ptr_d;

   logic [EN_W-1:0]      en_q      [N_CORES];
   logic [DATA_W-1:0]    hold_q    [N_CORES];
   logic [N_CORES-1:0]   pending_q;
   logic [N_CORES-1:0]   hit_s;
   logic [N_CORES-1:0]   clr_s;
   logic                 ovr_s;
   logic                 overrun_q;

   logic [DATA_W-1:0]    mem_data_q [FIFO_DEPTH];
   logic [CW-1:0]        mem_core_q [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_q;
   logic [AW-1:0]        rd_ptr_q;
   logic [AW-1:0]        rd_next_s;
   logic [AW:0]          count_q;
   logic                 full_s;
   logic                 push_s;
   logic                 pop_s;

   logic                 m_valid_q;
   logic [DATA_W-1:0]    m_data_q;
   logic [CW-1:0]        m_core_q;
   logic [15:0]          res_cnt_q;

   assign push_s    = (state_q == ST_PUSH);
   assign full_s    = (count_q == FULL_CNT);
   assign pop_s     = m_valid_q && m_ready;
   assign rd_next_s = rd_ptr_q + AW'(1);
   assign rr_ptr_d  = (rr_ptr_q == LAST_CORE) ? {CW{1'b0}} : (rr_ptr_q + CW'(1));

   // Per-core rising-edge detect of out_en==1 and the drain slot being freed this cycle
   always_comb begin
      hit_s = {N_CORES{1'b0}};
      clr_s = {N_CORES{1'b0}};
      for (int i = 0; i < N_CORES; i++) begin
         hit_s[i] = (core_en[i*EN_W +: EN_W] == EN_VALID) && (en_q[i] != EN_VALID);
         clr_s[i] = push_s && (rr_ptr_q == CW'(i));
      end
   end

   // A hit landing on the slot being drained in the same cycle refills it, so it is not an overrun
   assign ovr_s = |(hit_s & pending_q & ~clr_s);

   // Capture registers: one held result and a pending flag per core
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CORES; i++) begin
            en_q[i]   <= {EN_W{1'b0}};
            hold_q[i] <= {DATA_W{1'b0}};
         end
         pending_q <= {N_CORES{1'b0}};
      end else begin
         for (int i = 0; i < N_CORES; i++) begin
            en_q[i] <= core_en[i*EN_W +: EN_W];
            if (hit_s[i] && (!pending_q[i] || clr_s[i])) begin
               hold_q[i]    <= core_out[i*DATA_W +: DATA_W];
               pending_q[i] <= 1'b1;
            end else if (clr_s[i]) begin
               pending_q[i] <= 1'b0;
            end else begin
               pending_q[i] <= pending_q[i];
            end
         end
      end
   end

   // Sticky overrun flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun_q <= 1'b0;
      end else if (ovr_s) begin
         overrun_q <= 1'b1;
      end else begin
         overrun_q <= overrun_q;
      end
   end

   // Drain FSM: waits on the round-robin core, never skips it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= {CW{1'b0}};
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pending_q[rr_ptr_q] && !full_s) begin
                  state_q <= ST_PUSH;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_PUSH: begin
               rr_ptr_q <= rr_ptr_d;
               state_q  <= ST_IDLE;
            end
            default: begin
               state_q  <= ST_IDLE;
               rr_ptr_q <= {CW{1'b0}};
            end
         endcase
      end
   end

   // FIFO storage and pointers; the FSM only enters PUSH when there is room
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < FIFO_DEPTH; j++) begin
            mem_data_q[j] <= {DATA_W{1'b0}};
            mem_core_q[j] <= {CW{1'b0}};
         end
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {(AW + 1){1'b0}};
      end else begin
         if (push_s) begin
            mem_data_q[wr_ptr_q] <= hold_q[rr_ptr_q];
            mem_core_q[wr_ptr_q] <= rr_ptr_q;
            wr_ptr_q             <= wr_ptr_q + AW'(1);
         end else begin
            wr_ptr_q <= wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_q <= rd_next_s;
         end else begin
            rd_ptr_q <= rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_q <= count_q + ONE_CNT;
            2'b01:   count_q <= count_q - ONE_CNT;
            default: count_q <= count_q;
         endcase
      end
   end

   // Registered output stage mirrors the FIFO head one cycle after it is written
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid_q <= 1'b0;
         m_data_q  <= {DATA_W{1'b0}};
         m_core_q  <= {CW{1'b0}};
         res_cnt_q <= 16'd0;
      end else if (pop_s) begin
         m_valid_q <= (count_q > ONE_CNT);
         m_data_q  <= mem_data_q[rd_next_s];
         m_core_q  <= mem_core_q[rd_next_s];
         res_cnt_q <= res_cnt_q + 16'd1;
      end else if (!m_valid_q) begin
         m_valid_q <= (count_q != {(AW + 1){1'b0}});
         m_data_q  <= mem_data_q[rd_ptr_q];
         m_core_q  <= mem_core_q[rd_ptr_q];
         res_cnt_q <= res_cnt_q;
      end else begin
         m_valid_q <= m_valid_q;
         m_data_q  <= m_data_q;
         m_core_q  <= m_core_q;
         res_cnt_q <= res_cnt_q;
      end
   end

   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign m_core  = m_core_q;
   assign overrun = overrun_q;
   assign res_cnt = res_cnt_q;

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: latency, ordering, wrap, back-pressure, held enables, async reset.

module tb_result_collector;

   logic                  clk;
   logic                  rst_n;
   logic [24*28-1:0]      core_out;
   logic [24*4-1:0]       core_en;
   logic signed [27:0]    m_data;
   logic [4:0]            m_core;
   logic                  m_valid;
   logic                  m_ready;
   logic                  overrun;
   logic [15:0]           res_cnt;

   int checks = 0;
   int errors = 0;

   logic signed [27:0] q_data [$];
   logic [4:0]         q_core [$];

   result_collector dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .core_out (core_out),
      .core_en  (core_en),
      .m_data   (m_data),
      .m_core   (m_core),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .overrun  (overrun),
      .res_cnt  (res_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every accepted output; inputs change just after posedge so this is race-free
   always @(negedge clk) begin
      if (rst_n === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
         q_data.push_back(m_data);
         q_core.push_back(m_core);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int c, input logic [27:0] v);
      core_out[c*28 +: 28] = v;
      core_en[c*4 +: 4]    = 4'd1;
      tick();
      core_en[c*4 +: 4]    = 4'd0;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      core_en  = '0;
      core_out = '0;
      m_ready  = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      q_data.delete();
      q_core.delete();
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0 || m_data !== 28'sd0 || m_core !== 5'd0 || overrun !== 1'b0 || res_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_state: got valid=%b data=%0d core=%0d ovr=%b cnt=%0d expected all zero",
                  m_valid, m_data, m_core, overrun, res_cnt);
      end
   endtask

   task automatic test_single();
      do_reset();
      core_out[0 +: 28] = 28'h0000123;
      core_en[0 +: 4]   = 4'd1;
      tick();
      core_en[0 +: 4]   = 4'd0;
      repeat (2) tick();
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_early_valid: got %b expected 0 after 3 clk", m_valid);
      end
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1) begin
         errors++;
         $display("FAIL single_latency: got valid=%b expected 1 after 4 clk", m_valid);
      end
      checks++;
      if (m_data !== 28'sh0000123 || m_core !== 5'd0) begin
         errors++;
         $display("FAIL single_data: got data=%h core=%0d expected 0000123 core 0", m_data, m_core);
      end
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || m_data !== 28'sh0000123) begin
         errors++;
         $display("FAIL single_stable: got valid=%b data=%h expected 1 0000123", m_valid, m_data);
      end
      tick();
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (res_cnt !== 16'd1 || m_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_pop: got cnt=%0d valid=%b expected 1 0", res_cnt, m_valid);
      end
   endtask

   task automatic test_order();
      logic signed [27:0] exp_d [3];
      logic [4:0]         exp_c [3];
      exp_d[0] = 28'sd7;  exp_c[0] = 5'd0;
      exp_d[1] = 28'sd9;  exp_c[1] = 5'd1;
      exp_d[2] = -28'sd5; exp_c[2] = 5'd2;
      do_reset();
      m_ready = 1'b1;
      pulse(2, -28'sd5);
      pulse(0, 28'sd7);
      pulse(1, 28'sd9);
      repeat (30) tick();
      checks++;
      if (q_data.size() != 3) begin
         errors++;
         $display("FAIL order_count: got %0d outputs expected 3", q_data.size());
      end
      for (int k = 0; k < 3 && k < q_data.size(); k++) begin
         checks++;
         if (q_data[k] !== exp_d[k] || q_core[k] !== exp_c[k]) begin
            errors++;
            $display("FAIL order_item%0d: got data=%0d core=%0d expected data=%0d core=%0d",
                     k, q_data[k], q_core[k], exp_d[k], exp_c[k]);
         end
      end
   endtask

   task automatic test_wrap();
      logic signed [27:0] exp_d;
      logic [4:0]         exp_c;
      do_reset();
      m_ready = 1'b1;
      for (int k = 0; k < 48; k++) begin
         pulse(k % 24, 28'(k));
         tick();
      end
      repeat (30) tick();
      checks++;
      if (q_data.size() != 48) begin
         errors++;
         $display("FAIL wrap_count: got %0d outputs expected 48", q_data.size());
      end
      for (int k = 0; k < 48 && k < q_data.size(); k++) begin
         exp_d = 28'(k);
         exp_c = 5'(k % 24);
         checks++;
         if (q_data[k] !== exp_d || q_core[k] !== exp_c) begin
            errors++;
            $display("FAIL wrap_item%0d: got data=%0d core=%0d expected data=%0d core=%0d",
                     k, q_data[k], q_core[k], exp_d, exp_c);
         end
      end
      checks++;
      if (overrun !== 1'b0 || res_cnt !== 16'd48) begin
         errors++;
         $display("FAIL wrap_status: got ovr=%b cnt=%0d expected 0 48", overrun, res_cnt);
      end
   endtask

   task automatic test_back_pressure();
      logic signed [27:0] exp_d;
      logic [4:0]         exp_c;
      do_reset();
      m_ready = 1'b0;
      for (int k = 0; k < 10; k++) pulse(k, 28'(100 + k));
      repeat (40) tick();
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || m_data !== 28'sd100 || m_core !== 5'd0 || overrun !== 1'b0) begin
         errors++;
         $display("FAIL bp_head: got valid=%b data=%0d core=%0d ovr=%b expected 1 100 0 0",
                  m_valid, m_data, m_core, overrun);
      end
      pulse(9, 28'sd999);
      repeat (3) tick();
      @(negedge clk);
      checks++;
      if (overrun !== 1'b1) begin
         errors++;
         $display("FAIL bp_overrun: got %b expected 1", overrun);
      end
      checks++;
      if (m_data !== 28'sd100 || res_cnt !== 16'd0) begin
         errors++;
         $display("FAIL bp_stable: got data=%0d cnt=%0d expected 100 0", m_data, res_cnt);
      end
      tick();
      m_ready = 1'b1;
      repeat (40) tick();
      checks++;
      if (q_data.size() != 10 || res_cnt !== 16'd10) begin
         errors++;
         $display("FAIL bp_count: got %0d outputs cnt=%0d expected 10 10", q_data.size(), res_cnt);
      end
      for (int k = 0; k < 10 && k < q_data.size(); k++) begin
         exp_d = 28'(100 + k);
         exp_c = 5'(k);
         checks++;
         if (q_data[k] !== exp_d || q_core[k] !== exp_c) begin
            errors++;
            $display("FAIL bp_item%0d: got data=%0d core=%0d expected data=%0d core=%0d",
                     k, q_data[k], q_core[k], exp_d, exp_c);
         end
      end
   endtask

   task automatic test_held_enable();
      do_reset();
      m_ready = 1'b1;
      core_out[0 +: 28] = 28'sd55;
      core_en[0 +: 4]   = 4'd1;
      repeat (5) tick();
      core_en[0 +: 4]   = 4'd0;
      core_out[28 +: 28] = 28'sd77;
      core_en[4 +: 4]    = 4'd2;
      repeat (2) tick();
      core_en[4 +: 4]    = 4'd0;
      repeat (20) tick();
      checks++;
      if (q_data.size() != 1 || res_cnt !== 16'd1) begin
         errors++;
         $display("FAIL held_count: got %0d outputs cnt=%0d expected 1 1", q_data.size(), res_cnt);
      end
      checks++;
      if (q_data.size() < 1 || q_data[0] !== 28'sd55 || q_core[0] !== 5'd0) begin
         errors++;
         $display("FAIL held_item: got first data=%0d expected 55 core 0", (q_data.size() > 0) ? q_data[0] : 28'sd0);
      end
      pulse(1, 28'sd66);
      repeat (20) tick();
      checks++;
      if (q_data.size() != 2 || q_data[q_data.size()-1] !== 28'sd66 || q_core[q_core.size()-1] !== 5'd1) begin
         errors++;
         $display("FAIL held_en2_ignored: got %0d outputs, last data=%0d expected 2 outputs last 66 core 1",
                  q_data.size(), (q_data.size() > 0) ? q_data[q_data.size()-1] : 28'sd0);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      m_ready = 1'b0;
      for (int k = 0; k < 4; k++) pulse(k, 28'(k + 1));
      repeat (10) tick();
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (res_cnt !== 16'd1 || m_valid !== 1'b1) begin
         errors++;
         $display("FAIL areset_pre: got cnt=%0d valid=%b expected 1 1", res_cnt, m_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (m_valid !== 1'b0 || res_cnt !== 16'd0 || m_data !== 28'sd0 || m_core !== 5'd0) begin
         errors++;
         $display("FAIL areset_immediate: got valid=%b cnt=%0d data=%0d core=%0d expected all zero",
                  m_valid, res_cnt, m_data, m_core);
      end
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      q_data.delete();
      q_core.delete();
      m_ready = 1'b1;
      pulse(1, 28'sd11);
      pulse(0, 28'sd22);
      repeat (20) tick();
      checks++;
      if (q_data.size() != 2) begin
         errors++;
         $display("FAIL areset_count: got %0d outputs expected 2", q_data.size());
      end
      checks++;
      if (q_data.size() < 2 || q_data[0] !== 28'sd22 || q_core[0] !== 5'd0 ||
          q_data[1] !== 28'sd11 || q_core[1] !== 5'd1) begin
         errors++;
         $display("FAIL areset_order: got first core=%0d expected core0 22 then core1 11",
                  (q_core.size() > 0) ? q_core[0] : 5'd31);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      core_en  = '0;
      core_out = '0;
      m_ready  = 1'b0;
      test_reset();
      test_single();
      test_order();
      test_wrap();
      test_back_pressure();
      test_held_enable();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
